// File: rtl/dm_banked_ctrl_if.sv
// Request/response and device-window bus for dm_banked_ctrl.
// master: the MEM-stage requester and device side; slave: the controller.
interface dm_banked_ctrl_if;
    logic        Req;
    logic        Req_we;
    logic [31:0] Req_addr;
    logic [1:0]  Req_size;
    logic        Req_sign;
    logic [31:0] Req_wdata;
    logic        Exception;
    logic        Ready;
    logic        Rsp_valid;
    logic [31:0] Rsp_rdata;
    logic        Rsp_err;
    logic        Dev_req;
    logic        Dev_we;
    logic [31:0] Dev_addr;
    logic [3:0]  Dev_be;
    logic [31:0] Dev_wdata;
    logic [31:0] Dev_rdata;

    modport master (
        output Req, Req_we, Req_addr, Req_size, Req_sign, Req_wdata, Exception, Dev_rdata,
        input  Ready, Rsp_valid, Rsp_rdata, Rsp_err,
        input  Dev_req, Dev_we, Dev_addr, Dev_be, Dev_wdata
    );

    modport slave (
        input  Req, Req_we, Req_addr, Req_size, Req_sign, Req_wdata, Exception, Dev_rdata,
        output Ready, Rsp_valid, Rsp_rdata, Rsp_err,
        output Dev_req, Dev_we, Dev_addr, Dev_be, Dev_wdata
    );
endinterface

// File: rtl/dm_banked_ctrl.sv
// Data-memory controller for the MEM stage: byte-addressed sub-word loads/stores,
// device-window pass-through, zero-fill sweep after reset, 1-cycle registered response.
// Optional macro DM_STORE_TRACE_EN: print every committed memory store.
module dm_banked_ctrl #(
    parameter int unsigned ADDR_W     = 11,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] DEV_BASE   = 32'h0000_1F00,
    parameter logic [31:0] DEV_LIMIT  = 32'h0000_1F1B,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input logic            Clk,
    input logic            Reset_n,
    dm_banked_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StInit, StIdle} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_idx_q, init_idx_d;
    logic [31:0]         mem [DEPTH];

    logic [1:0]          lane;
    logic [31:0]         mem_off;
    logic [ADDR_W-1:0]   word_idx;
    logic                in_dev, in_mem, align_ok, accept, access_ok;
    logic                dev_hit, mem_wr, rsp_err_d;
    logic [3:0]          be;
    logic [31:0]         rd_word, shifted, ext_data, rdata_d, wdata_sh, merged;

    assign lane     = bus.Req_addr[1:0];
    assign mem_off  = bus.Req_addr - MEM_BASE;
    assign word_idx = mem_off[ADDR_W+1:2];
    assign in_dev   = (bus.Req_addr >= DEV_BASE) && (bus.Req_addr <= DEV_LIMIT);
    assign in_mem   = (bus.Req_addr >= MEM_BASE) && ((mem_off >> (ADDR_W + 2)) == 32'd0);
    assign accept   = bus.Req && (state_q == StIdle);
    assign wdata_sh = bus.Req_wdata << {lane, 3'b000};

    // Decode size/alignment into byte enables and response error.
    always_comb begin
        be       = 4'b0000;
        align_ok = 1'b0;
        case (bus.Req_size)
            2'd0: begin
                align_ok = 1'b1;
                be       = 4'b0001 << lane;
            end
            2'd1: begin
                align_ok = ~lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                align_ok = (lane == 2'b00);
                be       = 4'b1111;
            end
            default: begin
                align_ok = 1'b0;
                be       = 4'b0000;
            end
        endcase
        // Squashed accesses report no error and have no side effect.
        access_ok = accept && !bus.Exception && align_ok && (in_dev || in_mem);
        rsp_err_d = accept && !bus.Exception && (!align_ok || (!in_dev && !in_mem));
        dev_hit   = access_ok && in_dev;
        mem_wr    = access_ok && !in_dev && bus.Req_we;
    end

    // Load lane extraction and store read-modify-write merge.
    always_comb begin
        rd_word = in_dev ? bus.Dev_rdata : mem[word_idx];
        shifted = rd_word >> {lane, 3'b000};
        case (bus.Req_size)
            2'd0:    ext_data = bus.Req_sign ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'd0, shifted[7:0]};
            2'd1:    ext_data = bus.Req_sign ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'd0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
        rdata_d = (access_ok && !bus.Req_we) ? ext_data : 32'd0;
        merged  = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata_sh[8*b +: 8];
        end
    end

    assign bus.Ready     = (state_q == StIdle);
    assign bus.Dev_req   = dev_hit;
    assign bus.Dev_we    = dev_hit && bus.Req_we;
    assign bus.Dev_addr  = bus.Req_addr;
    assign bus.Dev_be    = be;
    assign bus.Dev_wdata = wdata_sh;

    // Init sweep next-state: advance index until the last word, then IDLE for good.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == StInit) begin
            init_idx_d = init_idx_q + 1'b1;
            if (&init_idx_q) state_d = StIdle;
        end
    end

    // State and sweep index registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= INIT_CLEAR ? StInit : StIdle;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Response registers; a pending response is dropped by reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.Rsp_valid <= 1'b0;
            bus.Rsp_err   <= 1'b0;
            bus.Rsp_rdata <= 32'd0;
        end else begin
            bus.Rsp_valid <= accept;
            bus.Rsp_err   <= rsp_err_d;
            bus.Rsp_rdata <= rdata_d;
        end
    end

    // Memory array: no reset; cleared by the sweep, written by committed stores.
    always_ff @(posedge Clk) begin
        if (Reset_n) begin
            if (state_q == StInit) begin
                mem[init_idx_q] <= 32'd0;
            end else if (mem_wr) begin
                mem[word_idx] <= merged;
`ifdef DM_STORE_TRACE_EN
                $display("*%08x <= %08x", MEM_BASE + 32'({word_idx, 2'b00}), merged);
`else
`endif
            end
        end
    end
endmodule
